seq_arith_unit: RTL and testbench

- Parametrised, multi-cycle successor to the team's 8-bit two-operand, ctrl-selected arithmetic block.
- Performs unsigned multiply, divide, add and multiply-accumulate on WIDTH-bit operands, producing a 2*WIDTH-bit result.
- Uses an iterative datapath with a start/busy/done handshake, so it sits behind a controller that issues one operation at a time.

---
 rtl/seq_arith_unit_if.sv | 25 ++
 rtl/seq_arith_unit.sv | 129 ++++++++++++
 tb/tb_seq_arith_unit.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_arith_unit_if.sv
// Handshake and operand bus for seq_arith_unit: the controller drives start,
// operands, ctrl and acc_clr, and the unit answers with busy/done/err/out.
interface seq_arith_unit_if #(
  parameter int WIDTH = 8
);
  logic               start;
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic [1:0]         ctrl;
  logic               acc_clr;
  logic               busy;
  logic               done;
  logic               err;
  logic [2*WIDTH-1:0] out;

  modport master (
    output start, A, B, ctrl, acc_clr,
    input  busy, done, err, out
  );

  modport slave (
    input  start, A, B, ctrl, acc_clr,
    output busy, done, err, out
  );
endinterface

// File: rtl/seq_arith_unit.sv
// Iterative unsigned MUL / DIV / ADD / MAC unit with a start/busy/done handshake.
// MUL/MAC use shift-add and DIV uses restoring division over one shared register.
module seq_arith_unit #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  seq_arith_unit_if.slave    bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [1:0] OP_MUL = 2'b00;
  localparam logic [1:0] OP_DIV = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_MAC = 2'b11;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   a_reg, b_reg;
  logic [1:0]         op_reg;
  logic [CW-1:0]      cnt_reg;
  logic [2*WIDTH-1:0] p_reg, p_next;
  logic [2*WIDTH-1:0] acc_reg, out_reg;
  logic               err_reg;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH-1:0]   div_diff;
  logic               div_ge;
  logic [2*WIDTH:0]   mac_sum;
  logic [WIDTH:0]     add_sum;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          if (bus.ctrl == OP_ADD || (bus.ctrl == OP_DIV && bus.B == '0))
            state_next = DONE;
          else
            state_next = RUN;
        end
      end
      RUN:     if (cnt_reg == LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // p_reg holds {partial product, multiplier} for MUL/MAC and {remainder, quotient} for DIV.
  always_comb begin
    mul_sum   = {1'b0, p_reg[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{p_reg[0]}} & a_reg};
    div_shift = {p_reg[2*WIDTH-1:WIDTH], p_reg[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, b_reg};
    div_diff  = div_shift[WIDTH-1:0] - b_reg;
    if (op_reg == OP_DIV)
      p_next = {(div_ge ? div_diff : div_shift[WIDTH-1:0]), p_reg[WIDTH-2:0], div_ge};
    else
      p_next = {mul_sum, p_reg[WIDTH-1:1]};
    mac_sum = {1'b0, acc_reg} + {1'b0, p_next};
    add_sum = {1'b0, bus.A} + {1'b0, bus.B};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_reg   <= '0;
      b_reg   <= '0;
      op_reg  <= '0;
      cnt_reg <= '0;
      p_reg   <= '0;
      acc_reg <= '0;
      out_reg <= '0;
      err_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.acc_clr) acc_reg <= '0;
          if (bus.start) begin
            a_reg   <= bus.A;
            b_reg   <= bus.B;
            op_reg  <= bus.ctrl;
            cnt_reg <= '0;
            p_reg   <= (bus.ctrl == OP_DIV) ? {{WIDTH{1'b0}}, bus.A} : {{WIDTH{1'b0}}, bus.B};
            if (bus.ctrl == OP_ADD) begin
              out_reg <= {{(WIDTH-1){1'b0}}, add_sum};
              err_reg <= 1'b0;
            end else if (bus.ctrl == OP_DIV && bus.B == '0) begin
              out_reg <= {bus.A, {WIDTH{1'b1}}};
              err_reg <= 1'b1;
            end
          end
        end
        RUN: begin
          p_reg   <= p_next;
          cnt_reg <= cnt_reg + CW'(1);
          if (cnt_reg == LAST) begin
            if (op_reg == OP_MAC) begin
              // Overflow past 2*WIDTH bits saturates the accumulator.
              if (mac_sum[2*WIDTH]) begin
                acc_reg <= '1;
                out_reg <= '1;
                err_reg <= 1'b1;
              end else begin
                acc_reg <= mac_sum[2*WIDTH-1:0];
                out_reg <= mac_sum[2*WIDTH-1:0];
                err_reg <= 1'b0;
              end
            end else begin
              out_reg <= p_next;
              err_reg <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state_reg != IDLE);
  assign bus.done = (state_reg == DONE);
  assign bus.err  = err_reg;
  assign bus.out  = out_reg;
endmodule

// File: tb/tb_seq_arith_unit.sv
// Directed and random checks of seq_arith_unit at WIDTH 8, 4 and 16 against a
// behavioural model, with expected results queued at issue and popped at done.
module tb_seq_arith_unit;
  localparam logic [1:0] MUL = 2'b00;
  localparam logic [1:0] DIV = 2'b01;
  localparam logic [1:0] ADD = 2'b10;
  localparam logic [1:0] MAC = 2'b11;

  typedef struct {
    logic [63:0] out;
    logic        err;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   failed = 0;
  exp_t sb[$];
  longint unsigned acc_m[3];

  seq_arith_unit_if #(.WIDTH(8))  bus8();
  seq_arith_unit_if #(.WIDTH(4))  bus4();
  seq_arith_unit_if #(.WIDTH(16)) bus16();

  seq_arith_unit #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));
  seq_arith_unit #(.WIDTH(4))  dut4  (.clk(clk), .rst(rst), .bus(bus4));
  seq_arith_unit #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

  always #5 clk = ~clk;

  function automatic int width_of(input int inst);
    return (inst == 0) ? 8 : (inst == 1) ? 4 : 16;
  endfunction

  function automatic logic get_done(input int inst);
    return (inst == 0) ? bus8.done : (inst == 1) ? bus4.done : bus16.done;
  endfunction

  function automatic logic get_busy(input int inst);
    return (inst == 0) ? bus8.busy : (inst == 1) ? bus4.busy : bus16.busy;
  endfunction

  function automatic logic get_err(input int inst);
    return (inst == 0) ? bus8.err : (inst == 1) ? bus4.err : bus16.err;
  endfunction

  function automatic logic [63:0] get_out(input int inst);
    logic [63:0] v;
    v = '0;
    case (inst)
      0:       v[15:0] = bus8.out;
      1:       v[7:0]  = bus4.out;
      default: v[31:0] = bus16.out;
    endcase
    return v;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int inst, input logic s, input logic [1:0] c,
                       input logic [31:0] a, input logic [31:0] b, input logic clr);
    case (inst)
      0: begin bus8.start = s;  bus8.ctrl = c;  bus8.A = a[7:0];   bus8.B = b[7:0];   bus8.acc_clr = clr;  end
      1: begin bus4.start = s;  bus4.ctrl = c;  bus4.A = a[3:0];   bus4.B = b[3:0];   bus4.acc_clr = clr;  end
      default: begin bus16.start = s; bus16.ctrl = c; bus16.A = a[15:0]; bus16.B = b[15:0]; bus16.acc_clr = clr; end
    endcase
  endtask

  // Reference behaviour computed with plain 64-bit arithmetic.
  task automatic model(input int inst, input logic [1:0] c, input longint unsigned a,
                       input longint unsigned b, input logic clr, output exp_t e);
    int w;
    longint unsigned mask, s;
    w    = width_of(inst);
    mask = (64'd1 << (2 * w)) - 1;
    if (clr) acc_m[inst] = 0;
    e.err = 1'b0;
    e.lat = w + 1;
    case (c)
      MUL: e.out = a * b;
      DIV: begin
        if (b == 0) begin
          e.out = (a << w) | ((64'd1 << w) - 1);
          e.err = 1'b1;
          e.lat = 1;
        end else begin
          e.out = ((a % b) << w) | (a / b);
        end
      end
      ADD: begin e.out = a + b; e.lat = 1; end
      default: begin
        s = acc_m[inst] + a * b;
        if (s > mask) begin acc_m[inst] = mask; e.err = 1'b1; end
        else acc_m[inst] = s;
        e.out = acc_m[inst];
      end
    endcase
  endtask

  task automatic run_op(input int inst, input logic [1:0] c, input longint unsigned a,
                        input longint unsigned b, input logic clr);
    exp_t e, got;
    int   lat;
    bit   seen;
    model(inst, c, a, b, clr, e);
    @(negedge clk);
    drive(inst, 1'b1, c, 32'(a), 32'(b), clr);
    sb.push_back(e);
    @(posedge clk); #1;
    // Scramble inputs to confirm the operands were latched.
    drive(inst, 1'b0, ~c, ~32'(a), ~32'(b), 1'b0);
    check("busy_after_start", {63'd0, get_busy(inst)}, 64'd1);
    lat  = 1;
    seen = 0;
    while (!seen && lat <= 2 * width_of(inst) + 4) begin
      if (get_done(inst)) seen = 1;
      else begin
        @(posedge clk); #1;
        lat++;
      end
    end
    check("done_seen", {63'd0, seen}, 64'd1);
    got = sb.pop_front();
    if (seen) begin
      check("out", get_out(inst), got.out);
      check("err", {63'd0, get_err(inst)}, {63'd0, got.err});
      check("latency", 64'(lat), 64'(got.lat));
    end
    $display("[TB] w=%0d op=%0d a=0x%0h b=0x%0h out=0x%0h err=%0b lat=%0d",
             width_of(inst), c, a, b, get_out(inst), get_err(inst), lat);
    @(posedge clk); #1;
    check("done_one_cycle", {63'd0, get_done(inst)}, 64'd0);
    check("idle_after_done", {63'd0, get_busy(inst)}, 64'd0);
  endtask

  initial begin
    int pulses;
    logic [1:0] c;
    longint unsigned a, b, hm;

    for (int i = 0; i < 3; i++) begin
      drive(i, 1'b0, MUL, 32'd0, 32'd0, 1'b0);
      acc_m[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("reset_out", get_out(0), 64'd0);
    check("reset_busy", {63'd0, bus8.busy}, 64'd0);
    check("reset_done", {63'd0, bus8.done}, 64'd0);
    check("reset_err", {63'd0, bus8.err}, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // MUL and DIV directed cases.
    run_op(0, MUL, 13, 11, 1'b0);
    check("mul_13x11", get_out(0), 64'h008F);
    run_op(0, DIV, 200, 7, 1'b0);
    check("div_200_7", get_out(0), 64'h041C);
    run_op(0, DIV, 8'h55, 0, 1'b0);
    check("div_by_zero", get_out(0), 64'h55FF);
    run_op(0, ADD, 8'hFF, 8'h01, 1'b0);
    check("add_carry", get_out(0), 64'h0100);

    // Held start: one ADD per IDLE entry, starts during DONE ignored.
    @(negedge clk);
    drive(0, 1'b1, ADD, 32'hFF, 32'h01, 1'b0);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (i == 4) bus8.start = 1'b0;
      if (bus8.done) begin
        pulses++;
        check("held_add_out", get_out(0), 64'h0100);
      end
    end
    check("held_start_pulses", 64'(pulses), 64'd3);

    // Random traffic at WIDTH=8 leaves the accumulator in an arbitrary state.
    for (int i = 0; i < 8; i++) begin
      c = 2'($urandom_range(0, 3));
      run_op(0, c, longint'($urandom_range(0, 255)), longint'($urandom_range(0, 255)), 1'b0);
    end

    // Standalone acc_clr, then MAC sequence with saturation.
    @(negedge clk);
    bus8.acc_clr = 1'b1;
    @(negedge clk);
    bus8.acc_clr = 1'b0;
    acc_m[0] = 0;
    run_op(0, MAC, 3, 4, 1'b0);
    check("mac_3x4", get_out(0), 64'h000C);
    run_op(0, MAC, 5, 6, 1'b0);
    check("mac_5x6", get_out(0), 64'h002A);
    run_op(0, MAC, 255, 255, 1'b0);
    check("mac_255_first", get_out(0), 64'hFE2B);
    run_op(0, MAC, 255, 255, 1'b0);
    check("mac_saturate", get_out(0), 64'hFFFF);
    run_op(0, MUL, 2, 2, 1'b0);
    check("mul_after_mac", get_out(0), 64'h0004);
    run_op(0, MAC, 0, 0, 1'b0);
    check("acc_persists", get_out(0), 64'hFFFF);
    run_op(0, DIV, 9, 0, 1'b0);
    run_op(0, MAC, 1, 1, 1'b1);
    check("clr_with_start", get_out(0), 64'h0001);
    run_op(0, DIV, 7, 0, 1'b0);

    // Reset in the middle of a MUL aborts it without a done pulse.
    @(negedge clk);
    drive(0, 1'b1, MUL, 32'd255, 32'd255, 1'b0);
    @(posedge clk); #1;
    bus8.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("abort_out", get_out(0), 64'd0);
    check("abort_busy", {63'd0, bus8.busy}, 64'd0);
    check("abort_err", {63'd0, bus8.err}, 64'd0);
    pulses = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (bus8.done) pulses++;
    end
    check("abort_no_done", 64'(pulses), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) acc_m[i] = 0;
    run_op(0, MUL, 2, 3, 1'b0);
    check("mul_after_reset", get_out(0), 64'h0006);

    // Random sweep on the 4-bit and 16-bit instances.
    for (int inst = 1; inst < 3; inst++) begin
      hm = (64'd1 << width_of(inst)) - 1;
      for (int i = 0; i < 12; i++) begin
        c = 2'($urandom_range(0, 3));
        a = longint'($urandom) & hm;
        b = ($urandom_range(0, 4) == 0) ? 0 : (longint'($urandom) & hm);
        run_op(inst, c, a, b, ($urandom_range(0, 5) == 0));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
